// File: rtl/load_store_unit.sv
// Load/store sequencer: one outstanding memory access at a time, with lane
// steering for byte/halfword/word, alignment rejection and an ack timeout.
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_request,
    input  logic        lsu_write,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Counter value of the last ACCESS cycle that may still see an ack.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        accept;
    logic        acked;
    logic        timed_out;
    logic        req_misaligned;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    assign accept    = (state_q == ST_IDLE) && lsu_request;
    assign acked     = (state_q == ST_ACCESS) && mem_ack;
    assign timed_out = (state_q == ST_ACCESS) && !mem_ack && (cnt_q == TIMEOUT_LAST);

    // Decode the incoming request: alignment, byte strobes, replicated data.
    always_comb begin
        req_misaligned = 1'b0;
        req_strb       = 4'b1111;
        req_wdata      = store_data;
        case (lsu_size)
            2'b00: begin
                req_strb  = 4'b0001 << address[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                req_misaligned = address[0];
                req_strb       = address[1] ? 4'b1100 : 4'b0011;
                req_wdata      = {2{store_data[15:0]}};
            end
            2'b10: begin
                req_misaligned = (address[1:0] != 2'b00);
            end
            default: begin
                req_misaligned = 1'b1;
            end
        endcase
    end

    // Select and extend the addressed lane of the returned word.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_byte = mem_rdata[7:0];
            2'b01:   rd_byte = mem_rdata[15:8];
            2'b10:   rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // State register plus captured request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            load_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Next state: an ack in the final counted cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_request) begin
                    state_d = req_misaligned ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || (cnt_q == TIMEOUT_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        bus_error_d  = bus_error_q;
        if (accept) begin
            cnt_d        = 8'd0;
            we_d         = lsu_write;
            size_d       = lsu_size;
            uns_d        = lsu_unsigned;
            addr_d       = address;
            wdata_d      = req_wdata;
            wstrb_d      = lsu_write ? req_strb : 4'b0000;
            load_data_d  = 32'h0;
            misaligned_d = req_misaligned;
            bus_error_d  = 1'b0;
        end else if (acked) begin
            if (!we_q) begin
                load_data_d = load_ext;
            end
        end else if (timed_out) begin
            bus_error_d = 1'b1;
            load_data_d = 32'h0;
        end else if (state_q == ST_ACCESS) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    always_comb begin
        lsu_busy   = (state_q != ST_IDLE);
        lsu_done   = (state_q == ST_DONE);
        mem_req    = (state_q == ST_ACCESS);
        mem_we     = (state_q == ST_ACCESS) && we_q;
        mem_wstrb  = (state_q == ST_ACCESS) ? wstrb_q : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        load_data  = load_data_q;
        misaligned = misaligned_q;
        bus_error  = bus_error_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses,
// a monitor checks memory-side beats and completions as they appear.
module tb_load_store_unit;

    localparam int T     = 4;
    localparam int NOACK = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_request = 1'b0;
    logic        lsu_write = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic        lsu_unsigned = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        lsu_busy, lsu_done, misaligned, bus_error;
    logic        mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_request(lsu_request), .lsu_write(lsu_write),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .address(address),
        .store_data(store_data), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
        .load_data(load_data), .misaligned(misaligned), .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        mis;
        logic        be;
        int          reqc;
        int          lat;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ack_delay = NOACK;
    int          ack_cnt = 0;
    logic [31:0] rd_word = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: acks after ack_delay ACCESS cycles, random noise otherwise.
    always @(negedge clk) begin
        if (mem_req) begin
            if (ack_delay != NOACK && ack_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_word;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            ack_cnt++;
        end else begin
            ack_cnt   = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // Monitor: memory beats, completions, and hold of results while idle.
    int          reqc_seen = 0;
    logic [31:0] last_ld = 32'h0;
    logic        last_mis = 1'b0;
    logic        last_be = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            reqc_seen = 0;
            last_ld   = 32'h0;
            last_mis  = 1'b0;
            last_be   = 1'b0;
        end else begin
            if (mem_req) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL mem_req_unexpected: got 1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    chk("cleared_results", {load_data[29:0], misaligned, bus_error}, 32'h0);
                    reqc_seen++;
                end
            end
            if (lsu_done) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL done_unexpected: got 1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("load_data", load_data, e.ld);
                    chk("misaligned", 32'(misaligned), 32'(e.mis));
                    chk("bus_error", 32'(bus_error), 32'(e.be));
                    chk("mem_req_cycles", 32'(reqc_seen), 32'(e.reqc));
                    chk("latency", 32'(cyc - e.n), 32'(e.lat));
                    chk("busy_in_done", 32'(lsu_busy), 32'h1);
                    $display("txn addr=%h we=%0d ld=%h mis=%0d be=%0d lat=%0d",
                             e.addr, e.we, load_data, misaligned, bus_error, cyc - e.n);
                    last_ld  = e.ld;
                    last_mis = e.mis;
                    last_be  = e.be;
                end
                reqc_seen = 0;
            end else if (!lsu_busy) begin
                chk("hold_load_data", load_data, last_ld);
                chk("hold_flags", {30'h0, misaligned, bus_error}, {30'h0, last_mis, last_be});
            end
        end
    end

    // Reference model: requests are expressed as plain arithmetic on the address.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rd, input int dly);
        exp_t        e;
        int          off;
        logic [31:0] sh, v;
        off    = int'(a % 4);
        e.addr = a - (a % 4);
        e.we   = w;
        e.mis  = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
        if (!w)            e.strb = 4'h0;
        else if (sz == 0)  e.strb = 4'(1 << off);
        else if (sz == 1)  e.strb = 4'(3 << (off & 2));
        else               e.strb = 4'hF;
        if (sz == 0)       e.wdata = (d & 32'hFF) * 32'h0101_0101;
        else if (sz == 1)  e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        else               e.wdata = d;
        if (sz == 0) begin
            sh = rd >> (8 * off);
            v  = sh & 32'hFF;
            if (!uns) v = (v ^ 32'h80) - 32'h80;
        end else if (sz == 1) begin
            sh = rd >> (8 * (off & 2));
            v  = sh & 32'hFFFF;
            if (!uns) v = (v ^ 32'h8000) - 32'h8000;
        end else begin
            v = rd;
        end
        e.be = 1'b0;
        e.ld = 32'h0;
        if (e.mis) begin
            e.reqc = 0; e.lat = 0;
        end else if (dly == NOACK) begin
            e.reqc = T; e.lat = T; e.be = 1'b1;
        end else begin
            e.reqc = dly + 1; e.lat = dly + 1;
            if (!w) e.ld = v;
        end
        e.n = 0;
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle; the request is sampled at the next edge.
    task automatic drive_req(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int dly);
        exp_t e;
        e = model(w, sz, uns, a, d, rd, dly);
        e.n = cyc + 1;
        lsu_write = w; lsu_size = sz; lsu_unsigned = uns;
        address = a; store_data = d;
        rd_word = rd; ack_delay = dly;
        lsu_request = 1'b1;
        q.push_back(e);
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int dly, input bit hold);
        int k;
        drive_req(w, sz, uns, a, d, rd, dly);
        @(posedge clk); #1;
        if (!hold) lsu_request = 1'b0;
        lsu_write = 1'($urandom); lsu_size = 2'($urandom);
        address = $urandom; store_data = $urandom; lsu_unsigned = 1'($urandom);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lsu_done) break;
        end
        if (k == 20) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: got no lsu_done required one within 20 cycles");
        end
        @(posedge clk); #1;
        lsu_request = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'h0, lsu_busy, lsu_done, mem_req, mem_we, misaligned, bus_error}, 32'h0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wstrb", 32'(mem_wstrb), 32'h0);
        rst_n = 1'b1;

        run_req(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
        run_req(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1, 1'b0);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
        run_req(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b1);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, NOACK, 1'b0);
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_5002, 32'h0, 32'h9876_5432, 3, 1'b1);
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_6001, 32'hFFFF_FF5A, 32'h0, 2, 1'b1);

        // Reset in the middle of an access, then a request on the first edge after release.
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h0, NOACK);
        @(posedge clk); #1;
        lsu_request = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_mem_req", 32'(mem_req), 32'h0);
        chk("midreset_outputs", {27'h0, lsu_busy, lsu_done, mem_we, misaligned, bus_error}, 32'h0);
        chk("midreset_mem_addr", mem_addr, 32'h0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int r, gap;
            r   = int'($urandom_range(0, 9));
            gap = int'($urandom_range(0, 2));
            run_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    (r < 8) ? r % 4 : NOACK, 1'($urandom));
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
